i2s_sample_feeder: RTL

I2S_SAMPLE_FEEDER -- requirements
Module: i2s_sample_feeder

---
 rtl/i2s_sample_feeder_pkg.sv | 23 ++
 rtl/i2s_sample_feeder_sync_fifo.sv | 53 +++++
 rtl/i2s_sample_feeder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/i2s_sample_feeder_pkg.sv
// rtl/i2s_sample_feeder_pkg.sv - shared audio-camera defaults, output FSM encoding, sample helper
package i2s_sample_feeder_pkg;

  localparam int DEF_SAMPLE_BITS = 24;
  localparam int DEF_DECIM       = 48;
  localparam int DEF_HOLD_CYCLES = 31250;
  localparam int DEF_FIFO_DEPTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_OFFER = 2'd2,
    ST_HOLD  = 2'd3
  } feeder_state_t;

  // Magnitude of a signed 16-bit sample; -32768 has no positive twin, so it saturates.
  function automatic logic [15:0] abs16(input logic [15:0] x);
    if (x == 16'h8000) return 16'h7FFF;
    else if (x[15]) return ~x + 16'd1;
    else return x;
  endfunction

endpackage

// File: rtl/i2s_sample_feeder_sync_fifo.sv
// rtl/i2s_sample_feeder_sync_fifo.sv - single-clock FIFO holding decimated sample magnitudes
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop in the same cycle frees a slot, so a push while full still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2s_sample_feeder.sv
// rtl/i2s_sample_feeder.sv - I2S left-channel capture, decimation and UART sample offer
module i2s_sample_feeder
  import i2s_sample_feeder_pkg::*;
#(
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int DECIM       = DEF_DECIM,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          i2s_bclk,
  input  logic                          i2s_lrck,
  input  logic                          i2s_sdata,
  output logic [15:0]                   data,
  output logic                          uart_ena,
  input  logic                          uart_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int BW = $clog2(SAMPLE_BITS + 1);
  localparam int DW = $clog2(DECIM + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic [1:0]             bclk_sync, lrck_sync, sdata_sync;
  logic                   bclk_prev, lrck_prev;
  logic                   bclk_rise, lrck_change;
  logic                   slot_valid, slot_left, skipped;
  logic [BW-1:0]          bit_cnt;
  logic [SAMPLE_BITS-2:0] shift;
  logic [SAMPLE_BITS-1:0] shift_next;
  logic                   word_done;
  logic [DW-1:0]          dec_cnt;
  logic                   push;
  logic [15:0]            push_data;
  logic                   pop;
  logic [15:0]            fifo_head;
  logic                   fifo_full, fifo_empty;
  feeder_state_t          state;
  logic [HW-1:0]          hold_cnt;

  assign bclk_rise   = bclk_sync[1] & ~bclk_prev;
  assign lrck_change = lrck_sync[1] ^ lrck_prev;
  assign shift_next  = {shift, sdata_sync[1]};
  assign word_done   = bclk_rise & ~lrck_change & slot_valid & slot_left & skipped
                     & (bit_cnt == BW'(SAMPLE_BITS - 1));
  assign pop         = (state == ST_LOAD);

  // No slot is trusted until an lrck transition has been seen, so a reset
  // released mid-word never yields a partial word.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bclk_sync  <= '0;
      lrck_sync  <= '0;
      sdata_sync <= '0;
      bclk_prev  <= 1'b0;
      lrck_prev  <= 1'b0;
      slot_valid <= 1'b0;
      slot_left  <= 1'b0;
      skipped    <= 1'b0;
      bit_cnt    <= '0;
      shift      <= '0;
      dec_cnt    <= '0;
      push       <= 1'b0;
      push_data  <= '0;
    end else begin
      bclk_sync  <= {bclk_sync[0], i2s_bclk};
      lrck_sync  <= {lrck_sync[0], i2s_lrck};
      sdata_sync <= {sdata_sync[0], i2s_sdata};
      bclk_prev  <= bclk_sync[1];
      lrck_prev  <= lrck_sync[1];
      push       <= 1'b0;
      if (lrck_change) begin
        slot_valid <= 1'b1;
        slot_left  <= ~lrck_sync[1];
        skipped    <= 1'b0;
        bit_cnt    <= '0;
      end else if (bclk_rise && slot_valid) begin
        if (!skipped) begin
          skipped <= 1'b1;
        end else if (bit_cnt < BW'(SAMPLE_BITS)) begin
          shift   <= shift_next[SAMPLE_BITS-2:0];
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (word_done) begin
        push      <= (dec_cnt == '0);
        push_data <= abs16(shift_next[SAMPLE_BITS-1 -: 16]);
        dec_cnt   <= (dec_cnt == DW'(DECIM - 1)) ? '0 : dec_cnt + 1'b1;
      end
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst)                             overflow <= 1'b0;
    else if (push && fifo_full && !pop)      overflow <= 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      data     <= '0;
      uart_ena <= 1'b0;
      hold_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) state <= ST_LOAD;
        end
        ST_LOAD: begin
          data     <= fifo_head;
          uart_ena <= 1'b1;
          state    <= ST_OFFER;
        end
        ST_OFFER: begin
          if (uart_ready) begin
            uart_ena <= 1'b0;
            hold_cnt <= '0;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HW'(HOLD_CYCLES - 1)) state <= ST_IDLE;
          else                                  hold_cnt <= hold_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
